mine_job_scheduler: RTL and testbench
=====================================

Name: mine_job_scheduler

Overview:
Sequences the master RAM controller port between the host mailbox and the mining core. Polls the host-to-FPGA flag word and fetches the 24-word (96-byte) job block when new work is flagged. Streams that block into the core's job shift register, then writes the FPGA-to-host acknowledge word. Arbitrates the single RAM port between job fetch and nonce write-back.

Parameters:
BASE_ADDR, 28'h8000000, address of the host-to-FPGA flag word
HW_FLAG_OFF, 28'h4, offset of the FPGA-to-host flag word
BLOCK_OFF, 28'h8, offset of the first job block word
NONCE_OFF, 28'h68, offset of the nonce result word
BLOCK_WORDS, 24, job block length in 32-bit words
NEW_JOB_MAGIC, 32'hAAAA0000, host flag value meaning new job ready
ACK_MAGIC, 32'h0000AAAA, value written to HW flag after job consumed
FOUND_MAGIC, 32'h0000BBBB, value written to HW flag after nonce written
POLL_GAP, 16, idle cycles between flag polls (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
rd_go  out  1  one-cycle read request pulse to RAM controller
wr_go  out  1  one-cycle write request pulse to RAM controller
mm_address  out  28  read/write address, valid during *_go and held until done
wr_data  out  32  write data, held from wr_go until wr_done
rd_valid  in  1  read data available (one word per pulse)
rd_data  in  32  read data
wr_done  in  1  write complete pulse
job_shift  out  1  shift enable into core job register, one per block word
job_word  out  32  job word, valid with job_shift
job_start  out  1  one-cycle pulse after last job word shifted
nonce_found  in  1  level from core; held until nonce_ack
nonce  in  32  candidate nonce, stable while nonce_found
nonce_ack  out  1  one-cycle pulse when nonce and FOUND flag written
busy  out  1  high in any state except POLL_WAIT

Behaviour:
- Reset (reset==0 at posedge): state POLL_WAIT, gap counter = POLL_GAP-1, word counter 0. rd_go, wr_go, job_shift, job_start, nonce_ack, busy = 0; mm_address = BASE_ADDR; wr_data = 0; job_word = 0. Reset mid-transaction abandons it; a late rd_valid/wr_done after reset is ignored in POLL_WAIT.
- States: POLL_WAIT, FLAG_RD, BLK_RD, ACK_WR, NONCE_WR, FOUND_WR.
- POLL_WAIT: gap counter decrements each cycle. Exit is taken when counter==0 or nonce_found==1.
  - nonce_found has priority: -> NONCE_WR, wr_go with mm_address=BASE_ADDR+NONCE_OFF, wr_data=nonce.
  - Otherwise -> FLAG_RD, rd_go with mm_address=BASE_ADDR.
  - The counter reloads POLL_GAP-1 on every entry to POLL_WAIT.
- FLAG_RD: wait for rd_valid.
  - rd_data==NEW_JOB_MAGIC -> BLK_RD: rd_go at BASE_ADDR+BLOCK_OFF, word counter=0.
  - Otherwise -> POLL_WAIT.
- BLK_RD: one read per word, addresses BLOCK_OFF+4*i, i=0..BLOCK_WORDS-1.
  - On rd_valid, in the same cycle: job_shift=1, job_word=rd_data, counter++.
  - If counter < BLOCK_WORDS-1: issue next rd_go the following cycle.
  - On last word: job_start pulses the next cycle -> ACK_WR (wr_go, HW flag addr, ACK_MAGIC).
- ACK_WR: on wr_done -> POLL_WAIT. The host must clear its flag before the next poll, or the job is refetched.
- NONCE_WR: on wr_done -> FOUND_WR (wr_go, HW flag addr, FOUND_MAGIC).
- FOUND_WR: on wr_done, nonce_ack pulses in the same cycle -> POLL_WAIT.
- nonce_found asserting during FLAG_RD/BLK_RD/ACK_WR is not lost: serviced at the next POLL_WAIT cycle 0.
- At most one outstanding RAM transaction. rd_go and wr_go are never both high. rd_valid in write states and wr_done in read states are ignored.
- Address arithmetic: 28-bit, BASE_ADDR+offset+4*i, no wrap within defaults (last word 0x8000064).
- Latency: flag-read rd_valid to first block rd_go = 1 cycle. Last-word rd_valid to job_start = 1 cycle; ACK_WR's wr_go falls in that same cycle.

Test Plan:
- Reset held 3 cycles then released, rd_valid held high -> all outputs 0 (mm_address=0x8000000); first rd_go exactly POLL_GAP cycles after release.
- Flag read returns 0x00000000 -> no block reads, back to POLL_WAIT, next rd_go POLL_GAP cycles later.
- Flag read returns 0xAAAA0000, block words 0..23 = i+0x100 with random 1-5 cycle rd latency:
  - 24 rd_go at 0x8000008..0x8000064; 24 job_shift with matching job_word.
  - One job_start, then wr_go at 0x8000004 with 0x0000AAAA.
- nonce_found with nonce=0xDEADBEEF asserted in POLL_WAIT -> wr 0xDEADBEEF @0x8000068, then 0x0000BBBB @0x8000004. nonce_ack on the second wr_done; no flag read in between.
- nonce_found raised mid BLK_RD at word 10 -> block completes and ACK written first, then nonce write starts one cycle after entering POLL_WAIT.
- reset asserted during BLK_RD word 5, stray rd_valid after release -> no job_shift, no job_start; fresh poll cycle begins.

Source files
------------

// File: rtl/mine_job_scheduler.sv
// mine_job_scheduler
//   Owns the single master port of the RAM controller. Polls the host flag
//   word, fetches a BLOCK_WORDS-word job block into the core's job shift
//   register, then acknowledges the job through the HW flag word. A nonce
//   reported by the core is written back, followed by the FOUND flag.
//
// Ports
//   clk, reset         clock, synchronous active-low reset
//   rd_go / wr_go      one-cycle read/write request pulses
//   mm_address         transaction address, held until rd_valid/wr_done
//   wr_data            write data, held until wr_done
//   rd_valid, rd_data  read return (one word per pulse)
//   wr_done            write completion pulse
//   job_shift/job_word job word strobe into the core (same cycle as rd_valid)
//   job_start          pulse after the last job word
//   nonce_found/nonce  core result level and value
//   nonce_ack          pulse when the nonce and FOUND flag are written
//   busy               high outside POLL_WAIT
module mine_job_scheduler #(
    parameter logic [27:0] BASE_ADDR     = 28'h8000000,
    parameter logic [27:0] HW_FLAG_OFF   = 28'h4,
    parameter logic [27:0] BLOCK_OFF     = 28'h8,
    parameter logic [27:0] NONCE_OFF     = 28'h68,
    parameter int          BLOCK_WORDS   = 24,
    parameter logic [31:0] NEW_JOB_MAGIC = 32'hAAAA0000,
    parameter logic [31:0] ACK_MAGIC     = 32'h0000AAAA,
    parameter logic [31:0] FOUND_MAGIC   = 32'h0000BBBB,
    parameter int          POLL_GAP      = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        rd_go,
    output logic        wr_go,
    output logic [27:0] mm_address,
    output logic [31:0] wr_data,
    input  logic        rd_valid,
    input  logic [31:0] rd_data,
    input  logic        wr_done,
    output logic        job_shift,
    output logic [31:0] job_word,
    output logic        job_start,
    input  logic        nonce_found,
    input  logic [31:0] nonce,
    output logic        nonce_ack,
    output logic        busy
);

    localparam int GW = $clog2(POLL_GAP + 1);
    localparam int CW = $clog2(BLOCK_WORDS + 1);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(POLL_GAP - 1);
    localparam logic [CW-1:0] LAST_WORD  = CW'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {
        POLL_WAIT, FLAG_RD, BLK_RD, ACK_WR, NONCE_WR, FOUND_WR
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [27:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rd_go_q, rd_go_d;
    logic          wr_go_q, wr_go_d;
    logic          job_start_q, job_start_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= POLL_WAIT;
            gap_q       <= GAP_RELOAD;
            cnt_q       <= '0;
            addr_q      <= BASE_ADDR;
            wdata_q     <= '0;
            rd_go_q     <= 1'b0;
            wr_go_q     <= 1'b0;
            job_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_go_q     <= rd_go_d;
            wr_go_q     <= wr_go_d;
            job_start_q <= job_start_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gap_d       = GAP_RELOAD;   // every non-poll state keeps the gap primed
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_go_d     = 1'b0;
        wr_go_d     = 1'b0;
        job_start_d = 1'b0;

        case (state_q)
            POLL_WAIT: begin
                gap_d = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
                // A pending nonce wins over polling so results are not delayed
                // by a job refetch.
                if (nonce_found) begin
                    state_d = NONCE_WR;
                    wr_go_d = 1'b1;
                    addr_d  = BASE_ADDR + NONCE_OFF;
                    wdata_d = nonce;
                end else if (gap_q == '0) begin
                    state_d = FLAG_RD;
                    rd_go_d = 1'b1;
                    addr_d  = BASE_ADDR;
                end
            end
            FLAG_RD: begin
                if (rd_valid) begin
                    if (rd_data == NEW_JOB_MAGIC) begin
                        state_d = BLK_RD;
                        rd_go_d = 1'b1;
                        addr_d  = BASE_ADDR + BLOCK_OFF;
                        cnt_d   = '0;
                    end else begin
                        state_d = POLL_WAIT;
                    end
                end
            end
            BLK_RD: begin
                if (rd_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_d     = ACK_WR;
                        job_start_d = 1'b1;
                        wr_go_d     = 1'b1;
                        addr_d      = BASE_ADDR + HW_FLAG_OFF;
                        wdata_d     = ACK_MAGIC;
                    end else begin
                        rd_go_d = 1'b1;
                        addr_d  = addr_q + 28'd4;
                    end
                end
            end
            ACK_WR: begin
                if (wr_done) state_d = POLL_WAIT;
            end
            NONCE_WR: begin
                if (wr_done) begin
                    state_d = FOUND_WR;
                    wr_go_d = 1'b1;
                    addr_d  = BASE_ADDR + HW_FLAG_OFF;
                    wdata_d = FOUND_MAGIC;
                end
            end
            FOUND_WR: begin
                if (wr_done) state_d = POLL_WAIT;
            end
            default: state_d = POLL_WAIT;
        endcase
    end

    // Job strobe and nonce ack follow the RAM return in the same cycle.
    assign job_shift  = (state_q == BLK_RD) && rd_valid;
    assign job_word   = job_shift ? rd_data : '0;
    assign nonce_ack  = (state_q == FOUND_WR) && wr_done;
    assign busy       = (state_q != POLL_WAIT);
    assign rd_go      = rd_go_q;
    assign wr_go      = wr_go_q;
    assign job_start  = job_start_q;
    assign mm_address = addr_q;
    assign wr_data    = wdata_q;

endmodule

// File: tb/tb_mine_job_scheduler.sv
module tb_mine_job_scheduler;

    localparam logic [27:0] BASE   = 28'h8000000;
    localparam logic [31:0] MAGIC  = 32'hAAAA0000;
    localparam logic [31:0] ACK    = 32'h0000AAAA;
    localparam logic [31:0] FOUND  = 32'h0000BBBB;
    localparam int          GAP    = 16;
    localparam int          WORDS  = 24;

    logic        clk, reset;
    logic        rd_go, wr_go, rd_valid, wr_done;
    logic [27:0] mm_address;
    logic [31:0] wr_data, rd_data, job_word, nonce;
    logic        job_shift, job_start, nonce_found, nonce_ack, busy;

    mine_job_scheduler dut (
        .clk(clk), .reset(reset), .rd_go(rd_go), .wr_go(wr_go),
        .mm_address(mm_address), .wr_data(wr_data), .rd_valid(rd_valid),
        .rd_data(rd_data), .wr_done(wr_done), .job_shift(job_shift),
        .job_word(job_word), .job_start(job_start), .nonce_found(nonce_found),
        .nonce(nonce), .nonce_ack(nonce_ack), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;
    int shifts  = 0;
    int starts  = 0;
    logic [31:0] sb[$];

    // passive pulse counter for job_start
    always @(negedge clk) if (reset && job_start) starts++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_rd_go();
        for (int n = 0; n < 64 && !rd_go; n++) @(negedge clk);
        chk("rd_go_seen", 32'(rd_go), 32'd1);
    endtask

    task automatic gap_to_rd_go(output int n);
        n = 0;
        while (!rd_go && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic serve_read(input logic [27:0] addr, input logic [31:0] data,
                              input int lat, input bit blk);
        wait_rd_go();
        chk("rd_addr", 32'(mm_address), 32'(addr));
        chk("rd_wr_excl", 32'(wr_go), 32'd0);
        repeat (lat - 1) @(negedge clk);
        rd_valid = 1'b1;
        rd_data  = data;
        if (blk) sb.push_back(data);
        #1;
        chk("job_shift", 32'(job_shift), 32'(blk));
        if (blk && job_shift && sb.size() > 0) begin
            shifts++;
            chk("job_word", job_word, sb.pop_front());
        end
        @(negedge clk);
        rd_valid = 1'b0;
        rd_data  = '0;
    endtask

    task automatic serve_write(input logic [27:0] addr, input logic [31:0] data,
                               input int lat, input bit exp_ack);
        bit saw_rd = 1'b0;
        for (int n = 0; n < 64 && !wr_go; n++) begin
            if (rd_go) saw_rd = 1'b1;
            @(negedge clk);
        end
        chk("wr_go_seen", 32'(wr_go), 32'd1);
        chk("wr_addr", 32'(mm_address), 32'(addr));
        chk("wr_data", wr_data, data);
        chk("wr_rd_excl", 32'(rd_go), 32'd0);
        repeat (lat - 1) begin
            @(negedge clk);
            if (rd_go) saw_rd = 1'b1;
        end
        wr_done = 1'b1;
        #1;
        chk("nonce_ack", 32'(nonce_ack), 32'(exp_ack));
        chk("wr_data_hold", wr_data, data);
        @(negedge clk);
        wr_done = 1'b0;
        chk("no_rd_in_wr", 32'(saw_rd), 32'd0);
    endtask

    task automatic run_block(input int nonce_at);
        int s0 = shifts;
        int j0 = starts;
        for (int i = 0; i < WORDS; i++) begin
            if (i == nonce_at) begin
                nonce_found = 1'b1;
                nonce       = 32'h12345678;
            end
            serve_read(BASE + 28'h8 + 28'(4 * i), 32'(i + 'h100),
                       int'($urandom_range(5, 1)), 1'b1);
        end
        chk("shift_count", 32'(shifts - s0), 32'(WORDS));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("job_start", 32'(job_start), 32'd1);
        serve_write(BASE + 28'h4, ACK, int'($urandom_range(4, 1)), 1'b0);
        chk("start_count", 32'(starts - j0), 32'd1);
        chk("idle_after_ack", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int j0;
        reset = 1'b0; rd_valid = 1'b1; rd_data = '0; wr_done = 1'b0;
        nonce_found = 1'b0; nonce = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // reset state with rd_valid held high
        chk("rst_rd_go", 32'(rd_go), 32'd0);
        chk("rst_wr_go", 32'(wr_go), 32'd0);
        chk("rst_job_shift", 32'(job_shift), 32'd0);
        chk("rst_job_start", 32'(job_start), 32'd0);
        chk("rst_nonce_ack", 32'(nonce_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(mm_address), 32'(BASE));
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_job_word", job_word, 32'd0);
        reset = 1'b1; rd_valid = 1'b0;
        gap_to_rd_go(n);
        chk("first_poll_gap", 32'(n), 32'(GAP));

        // flag read with no job
        serve_read(BASE, 32'h0, 2, 1'b0);
        chk("idle_after_flag", 32'(busy), 32'd0);
        gap_to_rd_go(n);
        chk("repoll_gap", 32'(n), 32'(GAP));

        // new job
        serve_read(BASE, MAGIC, 3, 1'b0);
        run_block(-1);

        // host cleared its flag
        serve_read(BASE, 32'h0, 1, 1'b0);

        // nonce found while polling
        nonce_found = 1'b1; nonce = 32'hDEADBEEF;
        @(negedge clk);
        serve_write(BASE + 28'h68, 32'hDEADBEEF, 3, 1'b0);
        serve_write(BASE + 28'h4, FOUND, 2, 1'b1);
        nonce_found = 1'b0;
        chk("idle_after_found", 32'(busy), 32'd0);

        // nonce raised mid-block: block and ACK complete first
        serve_read(BASE, MAGIC, 2, 1'b0);
        run_block(10);
        @(negedge clk);
        chk("nonce_wr_go", 32'(wr_go), 32'd1);
        serve_write(BASE + 28'h68, 32'h12345678, 2, 1'b0);
        serve_write(BASE + 28'h4, FOUND, 1, 1'b1);
        nonce_found = 1'b0;

        // reset during block word 5
        j0 = starts;
        serve_read(BASE, MAGIC, 2, 1'b0);
        for (int i = 0; i < 5; i++)
            serve_read(BASE + 28'h8 + 28'(4 * i), 32'(i + 'h100), 2, 1'b1);
        wait_rd_go();
        chk("w5_addr", 32'(mm_address), 32'(BASE + 28'h1C));
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_addr", 32'(mm_address), 32'(BASE));
        reset = 1'b1; rd_valid = 1'b1; rd_data = 32'h00000BAD;
        #1;
        chk("stray_no_shift", 32'(job_shift), 32'd0);
        @(negedge clk);
        rd_valid = 1'b0; rd_data = '0;
        chk("stray_busy", 32'(busy), 32'd0);
        gap_to_rd_go(n);
        chk("post_rst_gap", 32'(n), 32'(GAP - 1));
        chk("post_rst_no_start", 32'(starts - j0), 32'd0);
        serve_read(BASE, 32'h0, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
